// File: rtl/trdb_reg_master.sv
// rtl/trdb_reg_master.sv - per_* register bus initiator for read/write/flush-and-wait commands; poll timeout enabled by TRDB_REG_MASTER_TIMEOUT_EN
module trdb_reg_master #(
    parameter int unsigned               APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] CTRL_ADDR      = '0,
    parameter int unsigned               POLL_MAX       = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      per_valid_o,
    output logic                      per_we_o,
    output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
    output logic [31:0]               per_wdata_o,
    input  logic [31:0]               per_rdata_i,
    input  logic                      per_ready_i
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER,
        S_FL_WR,
        S_FL_POLL,
        S_RSP
    } state_t;

    state_t                    r_state;
    logic                      r_cmd_ready;
    logic                      r_rsp_valid;
    logic [31:0]               r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      r_per_valid;
    logic                      r_per_we;
    logic [APB_ADDR_WIDTH-1:0] r_per_addr;
    logic [31:0]               r_per_wdata;

    logic                      w_done;
    logic                      w_poll_timeout;

    assign w_done = r_per_valid & per_ready_i;

`ifdef TRDB_REG_MASTER_TIMEOUT_EN
    localparam int unsigned      CNT_W   = $clog2(POLL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_MAX);

    logic [CNT_W-1:0] r_poll_cnt;
    logic [CNT_W-1:0] w_poll_cnt_next;

    // The count after this poll completes; holds at POLL_MAX rather than wrapping
    assign w_poll_cnt_next = (r_poll_cnt == CNT_MAX) ? r_poll_cnt : r_poll_cnt + 1'b1;
    assign w_poll_timeout  = (w_poll_cnt_next == CNT_MAX);

    // Poll counter: cleared when the flush write lands, advanced on each completed poll read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_poll_cnt <= '0;
        end else if (r_state == S_FL_WR && w_done) begin
            r_poll_cnt <= '0;
        end else if (r_state == S_FL_POLL && w_done) begin
            r_poll_cnt <= w_poll_cnt_next;
        end
    end
`else
    logic w_unused_poll_max;

    // Without the timeout a flush polls until the responder confirms
    assign w_poll_timeout    = 1'b0;
    assign w_unused_poll_max = (POLL_MAX != 0);
`endif

    // Command sequencer: accept, bus transfer or flush write/poll loop, then hold the response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_per_valid <= 1'b0;
            r_per_we    <= 1'b0;
            r_per_addr  <= '0;
            r_per_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && cmd_valid_i) begin
                        r_cmd_ready <= 1'b0;
                        case (cmd_op_i)
                            OP_READ, OP_WRITE: begin
                                r_per_valid <= 1'b1;
                                r_per_we    <= cmd_op_i[0];
                                r_per_addr  <= cmd_addr_i;
                                r_per_wdata <= cmd_wdata_i;
                                r_state     <= S_XFER;
                            end
                            OP_FLUSH: begin
                                r_per_valid <= 1'b1;
                                r_per_we    <= 1'b1;
                                r_per_addr  <= CTRL_ADDR;
                                r_per_wdata <= 32'h1;
                                r_state     <= S_FL_WR;
                            end
                            default: begin
                                // Reserved op answers with an error and never touches the bus
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= '0;
                                r_rsp_err   <= 1'b1;
                                r_state     <= S_RSP;
                            end
                        endcase
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                S_XFER: begin
                    if (w_done) begin
                        r_per_valid <= 1'b0;
                        r_per_we    <= 1'b0;
                        r_rsp_rdata <= r_per_we ? 32'h0 : per_rdata_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end

                S_FL_WR: begin
                    // Keep per_valid high and turn straight into the first poll read
                    if (w_done) begin
                        r_per_we    <= 1'b0;
                        r_per_wdata <= '0;
                        r_state     <= S_FL_POLL;
                    end
                end

                S_FL_POLL: begin
                    if (r_per_valid) begin
                        if (per_ready_i) begin
                            r_rsp_rdata <= per_rdata_i;
                            if (!per_rdata_i[0]) begin
                                r_per_valid <= 1'b0;
                                r_rsp_err   <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_RSP;
                            end else if (w_poll_timeout) begin
                                r_per_valid <= 1'b0;
                                r_rsp_err   <= 1'b1;
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_RSP;
                            end else begin
                                // One idle bus cycle between consecutive polls
                                r_per_valid <= 1'b0;
                            end
                        end
                    end else begin
                        r_per_valid <= 1'b1;
                    end
                end

                S_RSP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign per_valid_o = r_per_valid;
    assign per_we_o    = r_per_we;
    assign per_addr_o  = r_per_addr;
    assign per_wdata_o = r_per_wdata;

endmodule
